// File: rtl/exe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : ARM-subset execute stage. It contains the Val2 shifter and
//               immediate path, the ALU, the NZCV status register, the branch
//               target adder and the EXE/MEM pipeline register.
//               Optional operand forwarding is enabled by EXE_FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          exe_WB_EN,
    input  logic          exe_MEM_R_EN,
    input  logic          exe_MEM_W_EN,
    input  logic          immediate,
    input  logic [3:0]    exe_EXE_CMD,
    input  logic          exe_B,
    input  logic          exe_S,
    input  logic [DW-1:0] PC,
    input  logic [DW-1:0] exe_Val_Rn,
    input  logic [DW-1:0] exe_Val_Rm,
    input  logic [7:0]    exe_immed_8,
    input  logic [3:0]    exe_rotate_imm,
    input  logic [23:0]   exe_Signed_imm_24,
    input  logic [3:0]    exe_Dest,
`ifdef EXE_FORWARDING_EN
    input  logic [1:0]    sel_src1,
    input  logic [1:0]    sel_src2,
    input  logic [DW-1:0] wb_value,
`endif
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr,
    output logic [DW-1:0] status_out,
    output logic          mem_WB_EN,
    output logic          mem_MEM_R_EN,
    output logic          mem_MEM_W_EN,
    output logic [DW-1:0] mem_ALU_res,
    output logic [DW-1:0] mem_Val_Rm,
    output logic [3:0]    mem_Dest
);

    localparam logic [3:0] c_CMD_MOV = 4'b0001;
    localparam logic [3:0] c_CMD_MVN = 4'b1001;
    localparam logic [3:0] c_CMD_ADD = 4'b0010;
    localparam logic [3:0] c_CMD_ADC = 4'b0011;
    localparam logic [3:0] c_CMD_SUB = 4'b0100;
    localparam logic [3:0] c_CMD_SBC = 4'b0101;
    localparam logic [3:0] c_CMD_AND = 4'b0110;
    localparam logic [3:0] c_CMD_ORR = 4'b0111;
    localparam logic [3:0] c_CMD_EOR = 4'b1000;

    logic          r_wb_en, r_mem_r_en, r_mem_w_en;
    logic [DW-1:0] r_alu_res, r_val_rm;
    logic [3:0]    r_dest;
    logic [3:0]    r_nzcv;

    logic [DW-1:0] w_rn, w_rm;
    logic [4:0]    w_rot_amt, w_sh_amt;
    logic [DW-1:0] w_imm_base, w_imm_rot, w_shifted, w_val2;
    logic [DW-1:0] w_b_op, w_res;
    logic          w_cin, w_arith, w_ovf, w_cmd_valid;
    logic [DW:0]   w_sum;
    logic [3:0]    w_nzcv_nx;

`ifdef EXE_FORWARDING_EN
    // Source 01 is this stage's own EXE/MEM result register.
    always_comb begin
        case (sel_src1)
            2'b01:   w_rn = r_alu_res;
            2'b10:   w_rn = wb_value;
            default: w_rn = exe_Val_Rn;
        endcase
        case (sel_src2)
            2'b01:   w_rm = r_alu_res;
            2'b10:   w_rm = wb_value;
            default: w_rm = exe_Val_Rm;
        endcase
    end
`else
    assign w_rn = exe_Val_Rn;
    assign w_rm = exe_Val_Rm;
`endif

    assign w_rot_amt  = {exe_rotate_imm, 1'b0};
    assign w_sh_amt   = {exe_rotate_imm, exe_immed_8[7]};
    assign w_imm_base = {{(DW-8){1'b0}}, exe_immed_8};
    // A left shift by the full width yields zero, so rotate-by-0 is exact.
    assign w_imm_rot  = (w_imm_base >> w_rot_amt) |
                        (w_imm_base << (6'd32 - {1'b0, w_rot_amt}));

    always_comb begin
        case (exe_immed_8[6:5])
            2'b00:   w_shifted = w_rm << w_sh_amt;
            2'b01:   w_shifted = w_rm >> w_sh_amt;
            2'b10:   w_shifted = $unsigned($signed(w_rm) >>> w_sh_amt);
            default: w_shifted = (w_rm >> w_sh_amt) |
                                 (w_rm << (6'd32 - {1'b0, w_sh_amt}));
        endcase
    end

    always_comb begin
        if (immediate)
            w_val2 = w_imm_rot;
        else if (exe_MEM_R_EN || exe_MEM_W_EN)
            w_val2 = {{(DW-12){1'b0}}, exe_rotate_imm, exe_immed_8};
        else
            w_val2 = w_shifted;
    end

    // Subtraction is Rn + ~Val2 + cin so the carry-out is the no-borrow flag.
    always_comb begin
        w_b_op  = w_val2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (exe_EXE_CMD)
            c_CMD_ADD: w_arith = 1'b1;
            c_CMD_ADC: begin w_arith = 1'b1; w_cin = r_nzcv[1]; end
            c_CMD_SUB: begin w_arith = 1'b1; w_b_op = ~w_val2; w_cin = 1'b1; end
            c_CMD_SBC: begin w_arith = 1'b1; w_b_op = ~w_val2; w_cin = r_nzcv[1]; end
            default:   ;
        endcase
    end

    assign w_sum = {1'b0, w_rn} + {1'b0, w_b_op} + {{DW{1'b0}}, w_cin};
    assign w_ovf = (w_rn[DW-1] == w_b_op[DW-1]) && (w_sum[DW-1] != w_rn[DW-1]);

    always_comb begin
        w_res       = '0;
        w_cmd_valid = 1'b1;
        case (exe_EXE_CMD)
            c_CMD_MOV: w_res = w_val2;
            c_CMD_MVN: w_res = ~w_val2;
            c_CMD_ADD, c_CMD_ADC,
            c_CMD_SUB, c_CMD_SBC: w_res = w_sum[DW-1:0];
            c_CMD_AND: w_res = w_rn & w_val2;
            c_CMD_ORR: w_res = w_rn | w_val2;
            c_CMD_EOR: w_res = w_rn ^ w_val2;
            default:   w_cmd_valid = 1'b0;
        endcase
    end

    assign w_nzcv_nx = {w_res[DW-1], (w_res == '0),
                        w_arith ? w_sum[DW] : r_nzcv[1],
                        w_arith ? w_ovf     : r_nzcv[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_alu_res  <= '0;
            r_val_rm   <= '0;
            r_dest     <= '0;
            r_nzcv     <= '0;
        end else if (!freeze) begin
            r_wb_en    <= exe_WB_EN    & ~exe_B;
            r_mem_r_en <= exe_MEM_R_EN & ~exe_B;
            r_mem_w_en <= exe_MEM_W_EN & ~exe_B;
            r_alu_res  <= w_res;
            r_val_rm   <= w_rm;
            r_dest     <= exe_Dest;
            if (exe_S && w_cmd_valid)
                r_nzcv <= w_nzcv_nx;
        end
    end

    assign branch_taken = exe_B;
    assign branch_addr  = PC + {{(DW-26){exe_Signed_imm_24[23]}}, exe_Signed_imm_24, 2'b00};
    assign status_out   = {r_nzcv, {(DW-4){1'b0}}};
    assign mem_WB_EN    = r_wb_en;
    assign mem_MEM_R_EN = r_mem_r_en;
    assign mem_MEM_W_EN = r_mem_w_en;
    assign mem_ALU_res  = r_alu_res;
    assign mem_Val_Rm   = r_val_rm;
    assign mem_Dest     = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Randomized bench for exe_stage against a behavioural model,
//               plus directed literal cases. Honors EXE_FORWARDING_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    localparam longint c_MAXS = 64'sd2147483647;
    localparam longint c_MINS = -64'sd2147483648;
    localparam longint c_TWO32 = 64'sd4294967296;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze, exe_WB_EN, exe_MEM_R_EN, exe_MEM_W_EN, immediate;
    logic [3:0]  exe_EXE_CMD;
    logic        exe_B, exe_S;
    logic [31:0] PC, exe_Val_Rn, exe_Val_Rm;
    logic [7:0]  exe_immed_8;
    logic [3:0]  exe_rotate_imm;
    logic [23:0] exe_Signed_imm_24;
    logic [3:0]  exe_Dest;
    logic [1:0]  sel_src1 = 2'b00;
    logic [1:0]  sel_src2 = 2'b00;
    logic [31:0] wb_value = 32'h0;

    logic        branch_taken;
    logic [31:0] branch_addr, status_out;
    logic        mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN;
    logic [31:0] mem_ALU_res, mem_Val_Rm;
    logic [3:0]  mem_Dest;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    exe_stage #(.DW(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .exe_WB_EN(exe_WB_EN), .exe_MEM_R_EN(exe_MEM_R_EN), .exe_MEM_W_EN(exe_MEM_W_EN),
        .immediate(immediate), .exe_EXE_CMD(exe_EXE_CMD), .exe_B(exe_B), .exe_S(exe_S),
        .PC(PC), .exe_Val_Rn(exe_Val_Rn), .exe_Val_Rm(exe_Val_Rm),
        .exe_immed_8(exe_immed_8), .exe_rotate_imm(exe_rotate_imm),
        .exe_Signed_imm_24(exe_Signed_imm_24), .exe_Dest(exe_Dest),
`ifdef EXE_FORWARDING_EN
        .sel_src1(sel_src1), .sel_src2(sel_src2), .wb_value(wb_value),
`endif
        .branch_taken(branch_taken), .branch_addr(branch_addr), .status_out(status_out),
        .mem_WB_EN(mem_WB_EN), .mem_MEM_R_EN(mem_MEM_R_EN), .mem_MEM_W_EN(mem_MEM_W_EN),
        .mem_ALU_res(mem_ALU_res), .mem_Val_Rm(mem_Val_Rm), .mem_Dest(mem_Dest)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] f_val2(input logic imm, input logic mr, input logic mw,
                                           input logic [31:0] rm, input logic [7:0] i8,
                                           input logic [3:0] rot);
        logic [31:0] v;
        int amt;
        if (imm) begin
            v = {24'b0, i8};
            for (int k = 0; k < 2 * int'(rot); k++) v = {v[0], v[31:1]};
        end else if (mr || mw) begin
            v = 32'(int'(rot) * 256 + int'(i8));
        end else begin
            amt = int'(rot) * 2 + int'(i8[7]);
            v = rm;
            for (int k = 0; k < amt; k++) begin
                case (i8[6:5])
                    2'b00:   v = {v[30:0], 1'b0};
                    2'b01:   v = {1'b0, v[31:1]};
                    2'b10:   v = {v[31], v[31:1]};
                    default: v = {v[0], v[31:1]};
                endcase
            end
        end
        return v;
    endfunction

    // Returns {valid, N, Z, C, V, result}
    function automatic logic [36:0] f_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl);
        logic [31:0] r;
        logic c, v, ar, ok;
        longint ua, ub, sa, sb, u, s, cin;
        ua = {32'b0, a}; ub = {32'b0, b};
        sa = $signed(a); sb = $signed(b);
        cin = fl[1] ? 64'sd1 : 64'sd0;
        u = 0; s = 0; r = 0; c = fl[1]; v = fl[0]; ar = 0; ok = 1;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010: begin u = ua + ub;       s = sa + sb;       ar = 1; c = (u >= c_TWO32); end
            4'b0011: begin u = ua + ub + cin; s = sa + sb + cin; ar = 1; c = (u >= c_TWO32); end
            4'b0100: begin u = ua - ub;       s = sa - sb;       ar = 1; c = (ua >= ub); end
            4'b0101: begin u = ua - ub - (1 - cin); s = sa - sb - (1 - cin); ar = 1;
                           c = (ua >= ub + (1 - cin)); end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: ok = 0;
        endcase
        if (ar) begin
            r = u[31:0];
            v = (s > c_MAXS) || (s < c_MINS);
        end
        return {ok, r[31], (r == 32'h0), c, v, r};
    endfunction

    function automatic logic [31:0] f_br(input logic [31:0] pc, input logic [23:0] imm);
        int off;
        off = imm[23] ? int'(imm) - 16777216 : int'(imm);
        return pc + 32'(off * 4);
    endfunction

    logic        m_wb, m_mr, m_mw;
    logic [31:0] m_res, m_rm;
    logic [3:0]  m_dest, m_nzcv;
    logic [31:0] m_src1, m_src2, m_v2;
    logic [36:0] m_alu;

    always_comb begin
        m_src1 = exe_Val_Rn;
        m_src2 = exe_Val_Rm;
`ifdef EXE_FORWARDING_EN
        if (sel_src1 == 2'b01) m_src1 = m_res;
        if (sel_src1 == 2'b10) m_src1 = wb_value;
        if (sel_src2 == 2'b01) m_src2 = m_res;
        if (sel_src2 == 2'b10) m_src2 = wb_value;
`endif
        m_v2  = f_val2(immediate, exe_MEM_R_EN, exe_MEM_W_EN, m_src2, exe_immed_8, exe_rotate_imm);
        m_alu = f_alu(exe_EXE_CMD, m_src1, m_v2, m_nzcv);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wb <= 0; m_mr <= 0; m_mw <= 0;
            m_res <= 0; m_rm <= 0; m_dest <= 0; m_nzcv <= 0;
        end else if (!freeze) begin
            m_wb   <= exe_WB_EN && !exe_B;
            m_mr   <= exe_MEM_R_EN && !exe_B;
            m_mw   <= exe_MEM_W_EN && !exe_B;
            m_res  <= m_alu[31:0];
            m_rm   <= m_src2;
            m_dest <= exe_Dest;
            if (exe_S && m_alu[36]) m_nzcv <= m_alu[35:32];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("alu_res", {32'b0, mem_ALU_res}, {32'b0, m_res});
            chk("val_rm", {32'b0, mem_Val_Rm}, {32'b0, m_rm});
            chk("ctl", {57'b0, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN, mem_Dest},
                       {57'b0, m_wb, m_mr, m_mw, m_dest});
            chk("status", {32'b0, status_out}, {32'b0, m_nzcv, 28'b0});
            chk("br_addr", {32'b0, branch_addr}, {32'b0, f_br(PC, exe_Signed_imm_24)});
            chk("br_taken", {63'b0, branch_taken}, {63'b0, exe_B});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        freeze            = ($urandom_range(0, 4) == 0);
        exe_WB_EN         = 1'($urandom);
        exe_MEM_R_EN      = ($urandom_range(0, 3) == 0);
        exe_MEM_W_EN      = ($urandom_range(0, 3) == 0);
        immediate         = 1'($urandom);
        exe_EXE_CMD       = 4'($urandom);
        exe_B             = ($urandom_range(0, 9) == 0);
        exe_S             = 1'($urandom);
        PC                = $urandom;
        exe_Val_Rn        = pick_val();
        exe_Val_Rm        = pick_val();
        exe_immed_8       = 8'($urandom);
        exe_rotate_imm    = 4'($urandom);
        exe_Signed_imm_24 = 24'($urandom);
        exe_Dest          = 4'($urandom);
        sel_src1          = 2'($urandom);
        sel_src2          = 2'($urandom);
        wb_value          = pick_val();
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic imm, input logic [7:0] i8, input logic [3:0] rot,
                          input logic s);
        freeze = 0; exe_WB_EN = 1; exe_MEM_R_EN = 0; exe_MEM_W_EN = 0; exe_B = 0;
        exe_EXE_CMD = cmd; exe_Val_Rn = rn; exe_Val_Rm = rm; immediate = imm;
        exe_immed_8 = i8; exe_rotate_imm = rot; exe_S = s; exe_Dest = 4'h3;
        PC = 32'h0; exe_Signed_imm_24 = 24'h0;
        sel_src1 = 2'b00; sel_src2 = 2'b00; wb_value = 32'h0;
    endtask

    initial begin
        rand_inputs();
        @(posedge clk);
        cmp_en = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_res", {32'b0, mem_ALU_res}, 64'h0);
            chk("rst_status", {32'b0, status_out}, 64'h0);
            chk("rst_ctl", {57'b0, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN, mem_Dest}, 64'h0);
            rand_inputs();
            tick();
        end
        rst = 1'b1;

        // ADDS 0x7FFFFFFF + 1
        set_op(4'b0010, 32'h7FFFFFFF, 32'h0, 1, 8'h01, 4'h0, 1);
        tick();
        chk("adds_res", {32'b0, mem_ALU_res}, 64'h80000000);
        chk("adds_flags", {32'b0, status_out}, 64'h90000000);

        // MOV with ASR #1
        set_op(4'b0001, 32'h0, 32'h80000001, 0, 8'hC0, 4'h0, 0);
        tick();
        chk("mov_asr", {32'b0, mem_ALU_res}, 64'hC0000000);
        chk("flags_kept", {32'b0, status_out}, 64'h90000000);

        // MOV 0xFF ror 8
        set_op(4'b0001, 32'h0, 32'h0, 1, 8'hFF, 4'h4, 0);
        tick();
        chk("mov_imm_rot", {32'b0, mem_ALU_res}, 64'hFF000000);

        // Branch with writeback and store enables set
        set_op(4'b0001, 32'h0, 32'h0, 1, 8'h55, 4'h0, 0);
        exe_B = 1; exe_MEM_W_EN = 1; PC = 32'h00000100; exe_Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_taken_lit", {63'b0, branch_taken}, 64'h1);
        chk("br_addr_lit", {32'b0, branch_addr}, 64'h000000F8);
        tick();
        chk("br_no_wb", {61'b0, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN}, 64'h0);
        chk("br_res", {32'b0, mem_ALU_res}, 64'h55);

        // SUBS 5-5 held under freeze
        set_op(4'b0100, 32'h5, 32'h0, 1, 8'h05, 4'h0, 1);
        exe_Dest = 4'hA;
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_res", {32'b0, mem_ALU_res}, 64'h55);
            chk("frz_status", {32'b0, status_out}, 64'h90000000);
            chk("frz_dest", {60'b0, mem_Dest}, 64'h3);
        end
        freeze = 0;
        tick();
        chk("subs_res", {32'b0, mem_ALU_res}, 64'h0);
        chk("subs_flags", {32'b0, status_out}, 64'h60000000);
        chk("subs_dest", {60'b0, mem_Dest}, 64'hA);

`ifdef EXE_FORWARDING_EN
        set_op(4'b0010, 32'h2, 32'h0, 1, 8'h03, 4'h0, 0);
        tick();
        chk("fwd_base", {32'b0, mem_ALU_res}, 64'h5);
        set_op(4'b0010, 32'h63, 32'h0, 1, 8'h0A, 4'h0, 0);
        sel_src1 = 2'b01;
        tick();
        chk("fwd_mem", {32'b0, mem_ALU_res}, 64'hF);
        set_op(4'b0010, 32'h63, 32'h0, 1, 8'h0A, 4'h0, 0);
        sel_src1 = 2'b10; wb_value = 32'h7;
        tick();
        chk("fwd_wb", {32'b0, mem_ALU_res}, 64'h11);
`endif

        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            if (n == 700) begin
                freeze = 1;
                #1;
                rst = 1'b0;
                #1;
                chk("mid_rst_res", {32'b0, mem_ALU_res}, 64'h0);
                chk("mid_rst_status", {32'b0, status_out}, 64'h0);
                chk("mid_rst_ctl", {25'b0, mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN, mem_Dest, mem_Val_Rm},
                    64'h0);
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the ID/EXE register and consumes its exe_* outputs.
- Generates Val2 through the shifter and immediate path, runs the ALU, and holds the NZCV status register. It returns the status register to ID, computes the branch target for IF, and registers results into the EXE/MEM boundary.

Parameters:
- DW, 32, datapath width (fixed at 32; parameterised only for readability).

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
freeze  in  1  MEM stall; holds the EXE/MEM register and the status register
exe_WB_EN, exe_MEM_R_EN, exe_MEM_W_EN  in  1 each  control bits from ID/EXE
immediate  in  1  operand-2 is a rotated immediate
exe_EXE_CMD  in  4  ALU command
exe_B, exe_S  in  1 each  branch; update flags
PC  in  32  PC+4 of the instruction
exe_Val_Rn, exe_Val_Rm  in  32 each  register operands
exe_immed_8  in  8  immediate / shift field
exe_rotate_imm  in  4  rotate / shift field
exe_Signed_imm_24  in  24  branch offset
exe_Dest  in  4  destination register
branch_taken  out  1  combinational, equals exe_B
branch_addr  out  32  combinational branch target
status_out  out  32  {N,Z,C,V,28'b0}; drives id_status_reg
mem_WB_EN, mem_MEM_R_EN, mem_MEM_W_EN  out  1 each  registered
mem_ALU_res  out  32  registered ALU result / memory address
mem_Val_Rm  out  32  registered store data
mem_Dest  out  4  registered destination

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0; NZCV=0000; status_out=0. Reset mid-stall also clears everything.
- Latency: one cycle. Inputs sampled at posedge N appear on the mem_* outputs after posedge N.
- Val2 selection:
  - immediate=1: {24'b0,immed_8} rotated right by 2*rotate_imm (0..30).
  - Else if MEM_R_EN or MEM_W_EN: zero-extended 12-bit {rotate_imm,immed_8}.
  - Else: Val_Rm shifted by shift_imm={rotate_imm,immed_8[7]} (0..31) using type immed_8[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes Val_Rm unchanged.
- ALU commands (Rn op Val2):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD (also LDR/STR address)
  - 0011 ADC: +C
  - 0100 SUB/CMP
  - 0101 SBC: Rn-Val2-~C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- Flags:
  - N=res[31]; Z=(res==0).
  - Arithmetic ops: C = 33-bit carry-out (SUB/SBC: C=1 means no borrow); V = signed overflow.
  - Logical ops and MOV/MVN: C and V are preserved.
- Status register:
  - Written at posedge when exe_S=1 and freeze=0.
  - A CMP in EXE is visible on status_out the following cycle.
- branch_addr = PC + sign_extend(Signed_imm_24)<<2, modulo 2^32.
- EXE/MEM register: loads when freeze=0. When freeze=1, all mem_* outputs and NZCV hold their values.
- When exe_B=1, the registered WB/MEM enables are loaded with 0 (branches produce no writeback).
- Simultaneous freeze=1 and exe_S=1: no flag update. The upstream stall logic re-presents the instruction.
- Flush of IF/ID and ID/EXE on branch_taken is handled upstream. This stage does not flush itself.

Optional Feature:
- Macro: EXE_FORWARDING_EN.
- Defined:
  - Adds input ports sel_src1 [1:0], sel_src2 [1:0] and wb_value [31:0].
  - Rn source: 00 exe_Val_Rn, 01 mem_ALU_res (own register), 10 wb_value, 11 exe_Val_Rn.
  - Rm source (for both the shifter and mem_Val_Rm) uses the same encoding with sel_src2.
- Undefined: these ports do not exist, and exe_Val_Rn/exe_Val_Rm are used directly.

Test Plan:
1. Reset: rst=0 for 2 cycles with random inputs -> all mem_* outputs = 0 and status_out = 0. Release rst; the first posedge loads normally.
2. ADDS with Rn=0x7FFFFFFF, immediate=1, immed_8=0x01, rotate=0, S=1 -> mem_ALU_res=0x80000000 next cycle; status_out N=1 Z=0 C=0 V=1 the cycle after.
3. Shifter paths:
   - MOV with Val_Rm=0x80000001, ASR by 1 -> mem_ALU_res=0xC0000000.
   - MOV with immediate immed_8=0xFF, rotate=4 -> mem_ALU_res=0xFF000000.
4. Branch: PC=0x00000100, exe_B=1, Signed_imm_24=0xFFFFFE (-2) -> branch_taken=1, branch_addr=0x000000F8 in the same cycle; registered mem_WB_EN=0.
5. freeze=1 for 3 cycles while SUBS 5-5 is presented -> mem_* outputs and NZCV hold. After release: mem_ALU_res=0, Z=1, C=1.
6. (EXE_FORWARDING_EN) Back-to-back ADD r1=2+3 then ADD with sel_src1=01, Val2=10 -> second mem_ALU_res=15. With sel_src1=10 and wb_value=7 -> result 17.
